mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares one single-ported Wishbone-style memory bus between the instruction-fetch port (IF) and the data-access port (MEM).
//  Sequences each bus cycle with an FSM, returns read data and a one-cycle ack, and raises stall requests toward ctrl.
//  Bounds every bus cycle with a timeout counter and reports hung slaves.
// PARAMETERS
//  TIMEOUT_CYCLES  255  cycles with cyc/stb high and no ack before forced termination (1..255)
//  TO_W            8    width of timeout counter; must satisfy 2**TO_W > TIMEOUT_CYCLES
// PORTS
//  clk          in   1   single clock; all state updates on rising edge
//  rst          in   1   synchronous, active-high reset (`RstEnable)
//  flush        in   1   pipeline flush; aborts IF transaction only
//  if_req       in   1   IF read request; held until if_ack
//  if_addr      in   32  IF word address
//  if_rdata     out  32  fetched instruction, valid with if_ack
//  if_ack       out  1   one-cycle completion pulse to IF
//  mem_req      in   1   MEM request; held with all fields stable until mem_ack
//  mem_we       in   1   1 = store, 0 = load
//  mem_sel      in   4   byte lanes
//  mem_addr     in   32  data address
//  mem_wdata    in   32  store data
//  mem_rdata    out  32  load data, valid with mem_ack
//  mem_ack      out  1   one-cycle completion pulse to MEM
//  stallreq_if  out  1   if_req & ~if_ack (combinational)
//  stallreq_mem out  1   mem_req & ~mem_ack (combinational)
//  bus_cyc_o, bus_stb_o  out 1  bus cycle/strobe (always equal)
//  bus_we_o     out  1   write enable
//  bus_sel_o    out  4   byte lanes
//  bus_adr_o    out  32  address
//  bus_dat_o    out  32  write data
//  bus_dat_i    in   32  read data
//  bus_ack_i    in   1   slave ack
//  bus_err      out  1   one-cycle pulse on timeout
// BEHAVIOUR
//  - Reset: state IDLE; all bus_* outputs, if/mem rdata and acks, bus_err, counter = 0. Reset mid-cycle drops cyc/stb at that edge; no ack issued.
//  - States: IDLE, BUS_IF, BUS_MEM. All bus_* and ack/rdata outputs registered.
//  - IDLE: mem_req -> BUS_MEM (fixed priority, older instruction wins); else if_req & ~flush -> BUS_IF. Latch request fields into bus_* outputs; cyc/stb high next cycle. bus_we_o=0, bus_sel_o=4'hF for IF.
//  - BUS_x: counter increments each cycle. bus_ack_i=1: capture bus_dat_i into x_rdata (loads/fetches; stores write nothing, rdata holds), pulse x_ack, drop cyc/stb, -> IDLE.
//  - Latency: req seen in IDLE at edge N, cyc/stb high from N+1, slave ack at edge M -> x_ack high cycle after M. One IDLE cycle between transactions (min 3 cycles per access with zero-wait slave).
//  - Timeout: counter reaches TIMEOUT_CYCLES without ack -> drop cyc/stb, pulse bus_err and x_ack with x_rdata = `ZeroWord, -> IDLE. Ack and timeout same cycle: ack wins, no bus_err.
//  - flush in BUS_IF: drop cyc/stb, no if_ack, -> IDLE; late bus_ack_i ignored. flush in BUS_MEM: ignored, access completes.
//  - flush in IDLE blocks a new IF grant that cycle; MEM grant unaffected.
//  - bus_ack_i while IDLE: ignored. Requester dropping req mid-transaction: cycle still completes; ack pulse delivered and discarded by requester.
//  - Counter clears on every entry to IDLE; TO_W-bit, never wraps (saturating compare).
// STRUCTURE
//  - defines.v gains: state encodings `ArbIdle/`ArbIf/`ArbMem (2-bit), `ArbStateBus; reuses `RstEnable, `ZeroWord, `WriteEnable/`WriteDisable.
//  - One sub-module natural: bus_timeout_cnt (clear, enable, expired flag, param TIMEOUT_CYCLES/TO_W). Arbiter FSM and output registers stay in mem_bus_arbiter.
// TESTING
//  1. IF only: if_req=1, if_addr=0x0000_0100, slave acks 1 cycle after stb with 0x3401_1100 -> bus_adr_o=0x100, sel=F, we=0; if_ack pulse 1 cycle, if_rdata=0x3401_1100; stallreq_if low only in ack cycle.
//  2. Simultaneous: if_req and mem_req (load, addr 0x200) same cycle -> MEM served first, IF granted after mem_ack + 1 IDLE cycle; stallreq_if stays high throughout.
//  3. Store: mem_we=1, sel=4'b0011, wdata=0xDEAD_BEEF, addr 0x204 -> bus_we_o=1, bus_sel_o=3, bus_dat_o=0xDEADBEEF; mem_ack after slave ack; mem_rdata unchanged.
//  4. Timeout: TIMEOUT_CYCLES=4, slave never acks -> cyc drops after 4 cycles, bus_err and mem_ack pulse together, mem_rdata=0; ack on exactly 4th cycle -> normal completion, bus_err=0.
//  5. Flush: flush during BUS_IF wait state -> cyc drops next edge, no if_ack; subsequent late bus_ack_i ignored; flush during BUS_MEM -> access completes normally.
//  6. Reset mid-transaction: rst=1 while cyc high -> all outputs 0 next edge, state IDLE, no ack.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the IF/MEM memory bus arbiter.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_IF   = 2'b01,
    ARB_MEM  = 2'b10
  } arb_state_t;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  localparam logic [3:0]  SEL_ALL   = 4'hF;
  localparam logic        WRITE_EN  = 1'b1;
  localparam logic        WRITE_DIS = 1'b0;

endpackage

// File: rtl/mem_bus_arbiter_timeout_cnt.sv
// Per-bus-cycle watchdog: counts cycles while enabled and flags the last allowed cycle.
module mem_bus_arbiter_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TO_W-1:0] count_reg;

  // Expired marks the TIMEOUT_CYCLES-th cycle of the access, so an ack in that
  // same cycle can still win over the forced termination.
  assign expired = (count_reg >= TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_reg <= '0;
    end else if (enable && !expired) begin
      count_reg <= count_reg + TO_W'(1);
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one single-ported Wishbone-style bus between instruction fetch and
// data access, with fixed MEM priority, registered outputs and a bus-cycle timeout.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [3:0]  mem_sel,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ack,
  output logic        stallreq_if,
  output logic        stallreq_mem,
  output logic        bus_cyc_o,
  output logic        bus_stb_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_adr_o,
  output logic [31:0] bus_dat_o,
  input  logic [31:0] bus_dat_i,
  input  logic        bus_ack_i,
  output logic        bus_err
);

  arb_state_t  state_reg;
  logic        bus_cyc_reg;
  logic        bus_we_reg;
  logic [3:0]  bus_sel_reg;
  logic [31:0] bus_adr_reg;
  logic [31:0] bus_dat_reg;
  logic [31:0] if_rdata_reg;
  logic        if_ack_reg;
  logic [31:0] mem_rdata_reg;
  logic        mem_ack_reg;
  logic        bus_err_reg;

  logic        in_bus;
  logic        leaving_bus;
  logic        to_expired;

  assign in_bus      = (state_reg != ARB_IDLE);
  assign leaving_bus = ((state_reg == ARB_IF)  && (flush || bus_ack_i || to_expired)) ||
                       ((state_reg == ARB_MEM) && (bus_ack_i || to_expired));

  mem_bus_arbiter_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_W          (TO_W)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (!in_bus || leaving_bus),
    .enable (in_bus),
    .expired(to_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ARB_IDLE;
      bus_cyc_reg   <= 1'b0;
      bus_we_reg    <= WRITE_DIS;
      bus_sel_reg   <= 4'h0;
      bus_adr_reg   <= ZERO_WORD;
      bus_dat_reg   <= ZERO_WORD;
      if_rdata_reg  <= ZERO_WORD;
      if_ack_reg    <= 1'b0;
      mem_rdata_reg <= ZERO_WORD;
      mem_ack_reg   <= 1'b0;
      bus_err_reg   <= 1'b0;
    end else begin
      if_ack_reg  <= 1'b0;
      mem_ack_reg <= 1'b0;
      bus_err_reg <= 1'b0;
      case (state_reg)
        ARB_IDLE: begin
          // MEM belongs to the older instruction, so it always wins the grant.
          if (mem_req) begin
            state_reg   <= ARB_MEM;
            bus_cyc_reg <= 1'b1;
            bus_we_reg  <= mem_we;
            bus_sel_reg <= mem_sel;
            bus_adr_reg <= mem_addr;
            bus_dat_reg <= mem_wdata;
          end else if (if_req && !flush) begin
            state_reg   <= ARB_IF;
            bus_cyc_reg <= 1'b1;
            bus_we_reg  <= WRITE_DIS;
            bus_sel_reg <= SEL_ALL;
            bus_adr_reg <= if_addr;
            bus_dat_reg <= ZERO_WORD;
          end
        end
        ARB_IF: begin
          // A flushed fetch is abandoned silently; any later ack lands in IDLE.
          if (flush) begin
            state_reg   <= ARB_IDLE;
            bus_cyc_reg <= 1'b0;
          end else if (bus_ack_i) begin
            state_reg    <= ARB_IDLE;
            bus_cyc_reg  <= 1'b0;
            if_rdata_reg <= bus_dat_i;
            if_ack_reg   <= 1'b1;
          end else if (to_expired) begin
            state_reg    <= ARB_IDLE;
            bus_cyc_reg  <= 1'b0;
            if_rdata_reg <= ZERO_WORD;
            if_ack_reg   <= 1'b1;
            bus_err_reg  <= 1'b1;
          end
        end
        ARB_MEM: begin
          if (bus_ack_i) begin
            state_reg   <= ARB_IDLE;
            bus_cyc_reg <= 1'b0;
            mem_ack_reg <= 1'b1;
            if (bus_we_reg != WRITE_EN) begin
              mem_rdata_reg <= bus_dat_i;
            end
          end else if (to_expired) begin
            state_reg     <= ARB_IDLE;
            bus_cyc_reg   <= 1'b0;
            mem_rdata_reg <= ZERO_WORD;
            mem_ack_reg   <= 1'b1;
            bus_err_reg   <= 1'b1;
          end
        end
        default: begin
          state_reg   <= ARB_IDLE;
          bus_cyc_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus_cyc_o    = bus_cyc_reg;
  assign bus_stb_o    = bus_cyc_reg;
  assign bus_we_o     = bus_we_reg;
  assign bus_sel_o    = bus_sel_reg;
  assign bus_adr_o    = bus_adr_reg;
  assign bus_dat_o    = bus_dat_reg;
  assign if_rdata     = if_rdata_reg;
  assign if_ack       = if_ack_reg;
  assign mem_rdata    = mem_rdata_reg;
  assign mem_ack      = mem_ack_reg;
  assign bus_err      = bus_err_reg;
  assign stallreq_if  = if_req & ~if_ack_reg;
  assign stallreq_mem = mem_req & ~mem_ack_reg;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with TIMEOUT_CYCLES=4 and a hand-driven slave.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stallreq_if;
  logic        stallreq_mem;
  logic        bus_cyc_o;
  logic        bus_stb_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_adr_o;
  logic [31:0] bus_dat_o;
  logic [31:0] bus_dat_i;
  logic        bus_ack_i;
  logic        bus_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(4), .TO_W(8)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem),
    .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o),
    .bus_sel_o(bus_sel_o), .bus_adr_o(bus_adr_o), .bus_dat_o(bus_dat_o),
    .bus_dat_i(bus_dat_i), .bus_ack_i(bus_ack_i), .bus_err(bus_err)
  );

  // Outputs are sampled and inputs driven right after each falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; if_req = 1'b0; if_addr = '0; mem_req = 1'b0;
    mem_we = 1'b0; mem_sel = '0; mem_addr = '0; mem_wdata = '0;
    bus_dat_i = '0; bus_ack_i = 1'b0;
    repeat (3) step();
    checks++; if ({bus_cyc_o, bus_stb_o, bus_we_o, bus_sel_o, bus_adr_o, bus_dat_o} !== 71'd0) begin
      errors++; $display("FAIL reset_bus: got cyc=%0b we=%0b sel=%h adr=%h dat=%h required all 0", bus_cyc_o, bus_we_o, bus_sel_o, bus_adr_o, bus_dat_o); end
    checks++; if ({if_ack, mem_ack, bus_err, stallreq_if, stallreq_mem} !== 5'd0) begin
      errors++; $display("FAIL reset_flags: got %b required 00000", {if_ack, mem_ack, bus_err, stallreq_if, stallreq_mem}); end
    checks++; if ({if_rdata, mem_rdata} !== 64'd0) begin
      errors++; $display("FAIL reset_rdata: got if=%h mem=%h required 0", if_rdata, mem_rdata); end
    rst = 1'b0;
    $display("txn reset done");
  endtask

  task automatic test_if_only();
    if_req = 1'b1; if_addr = 32'h0000_0100;
    step();
    checks++; if ({bus_cyc_o, bus_stb_o, bus_we_o, bus_sel_o, bus_adr_o} !== {3'b110, 4'hF, 32'h100}) begin
      errors++; $display("FAIL if_bus: got cyc=%0b stb=%0b we=%0b sel=%h adr=%h required 1 1 0 f 00000100", bus_cyc_o, bus_stb_o, bus_we_o, bus_sel_o, bus_adr_o); end
    checks++; if ({stallreq_if, if_ack} !== 2'b10) begin
      errors++; $display("FAIL if_wait: got stall=%0b ack=%0b required 1 0", stallreq_if, if_ack); end
    bus_ack_i = 1'b1; bus_dat_i = 32'h3401_1100;
    step();
    checks++; if ({if_ack, stallreq_if, bus_cyc_o} !== 3'b100 || if_rdata !== 32'h3401_1100) begin
      errors++; $display("FAIL if_ack: got ack=%0b stall=%0b cyc=%0b rdata=%h required 1 0 0 34011100", if_ack, stallreq_if, bus_cyc_o, if_rdata); end
    if_req = 1'b0; bus_ack_i = 1'b0;
    step();
    checks++; if (if_ack !== 1'b0) begin
      errors++; $display("FAIL if_ack_pulse: got %0b required 0", if_ack); end
    $display("txn IF read adr=00000100 rdata=%h", if_rdata);
  endtask

  task automatic test_simultaneous();
    if_req = 1'b1; if_addr = 32'h0000_0104;
    mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h0000_0200;
    step();
    checks++; if (bus_adr_o !== 32'h200 || bus_we_o !== 1'b0 || {stallreq_if, stallreq_mem} !== 2'b11) begin
      errors++; $display("FAIL prio_mem_first: got adr=%h we=%0b stalls=%b required 00000200 0 11", bus_adr_o, bus_we_o, {stallreq_if, stallreq_mem}); end
    bus_ack_i = 1'b1; bus_dat_i = 32'h1111_2222;
    step();
    checks++; if ({mem_ack, stallreq_mem, stallreq_if, bus_cyc_o} !== 4'b1010 || mem_rdata !== 32'h1111_2222) begin
      errors++; $display("FAIL prio_mem_ack: got ack=%0b stm=%0b sti=%0b cyc=%0b rdata=%h required 1 0 1 0 11112222", mem_ack, stallreq_mem, stallreq_if, bus_cyc_o, mem_rdata); end
    mem_req = 1'b0; bus_ack_i = 1'b0;
    step();
    checks++; if (bus_cyc_o !== 1'b1 || bus_adr_o !== 32'h104 || stallreq_if !== 1'b1) begin
      errors++; $display("FAIL prio_if_next: got cyc=%0b adr=%h stall=%0b required 1 00000104 1", bus_cyc_o, bus_adr_o, stallreq_if); end
    bus_ack_i = 1'b1; bus_dat_i = 32'h5555_6666;
    step();
    checks++; if (if_ack !== 1'b1 || if_rdata !== 32'h5555_6666) begin
      errors++; $display("FAIL prio_if_ack: got ack=%0b rdata=%h required 1 55556666", if_ack, if_rdata); end
    if_req = 1'b0; bus_ack_i = 1'b0;
    step();
    $display("txn MEM load 00000200 then IF 00000104");
  endtask

  task automatic test_store();
    mem_req = 1'b1; mem_we = 1'b1; mem_sel = 4'b0011; mem_addr = 32'h0000_0204; mem_wdata = 32'hDEAD_BEEF;
    step();
    checks++; if ({bus_we_o, bus_sel_o} !== 5'b1_0011 || bus_dat_o !== 32'hDEAD_BEEF || bus_adr_o !== 32'h204) begin
      errors++; $display("FAIL store_bus: got we=%0b sel=%h dat=%h adr=%h required 1 3 deadbeef 00000204", bus_we_o, bus_sel_o, bus_dat_o, bus_adr_o); end
    step();
    checks++; if (bus_cyc_o !== 1'b1 || mem_ack !== 1'b0) begin
      errors++; $display("FAIL store_wait: got cyc=%0b ack=%0b required 1 0", bus_cyc_o, mem_ack); end
    bus_ack_i = 1'b1; bus_dat_i = 32'hFFFF_FFFF;
    step();
    checks++; if (mem_ack !== 1'b1 || mem_rdata !== 32'h1111_2222 || bus_cyc_o !== 1'b0) begin
      errors++; $display("FAIL store_ack: got ack=%0b rdata=%h cyc=%0b required 1 11112222 0", mem_ack, mem_rdata, bus_cyc_o); end
    mem_req = 1'b0; mem_we = 1'b0; bus_ack_i = 1'b0;
    step();
    $display("txn MEM store 00000204 data=deadbeef");
  endtask

  task automatic test_timeout();
    int n;
    mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h0000_0300;
    step();
    n = 0;
    while (bus_cyc_o === 1'b1 && n < 20) begin
      step(); n++;
    end
    checks++; if (n !== 4) begin
      errors++; $display("FAIL timeout_len: got %0d cycles of cyc required 4", n); end
    checks++; if ({bus_err, mem_ack} !== 2'b11 || mem_rdata !== 32'h0) begin
      errors++; $display("FAIL timeout_err: got err=%0b ack=%0b rdata=%h required 1 1 00000000", bus_err, mem_ack, mem_rdata); end
    mem_req = 1'b0;
    step();
    checks++; if ({bus_err, mem_ack} !== 2'b00) begin
      errors++; $display("FAIL timeout_pulse: got err=%0b ack=%0b required 0 0", bus_err, mem_ack); end
    $display("txn MEM load 00000300 timed out");
    // Ack arriving in the last allowed cycle must complete normally.
    mem_req = 1'b1;
    step();
    repeat (3) step();
    checks++; if (bus_cyc_o !== 1'b1) begin
      errors++; $display("FAIL edge_cyc4: got cyc=%0b in 4th cycle required 1", bus_cyc_o); end
    bus_ack_i = 1'b1; bus_dat_i = 32'hCAFE_F00D;
    step();
    checks++; if ({mem_ack, bus_err} !== 2'b10 || mem_rdata !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL edge_ack: got ack=%0b err=%0b rdata=%h required 1 0 cafef00d", mem_ack, bus_err, mem_rdata); end
    mem_req = 1'b0; bus_ack_i = 1'b0;
    step();
    $display("txn MEM load 00000300 acked on last cycle rdata=%h", mem_rdata);
  endtask

  task automatic test_flush();
    if_req = 1'b1; if_addr = 32'h0000_0108;
    step();
    checks++; if (bus_cyc_o !== 1'b1) begin
      errors++; $display("FAIL flush_if_start: got cyc=%0b required 1", bus_cyc_o); end
    flush = 1'b1;
    step();
    checks++; if ({bus_cyc_o, if_ack} !== 2'b00) begin
      errors++; $display("FAIL flush_if_abort: got cyc=%0b ack=%0b required 0 0", bus_cyc_o, if_ack); end
    flush = 1'b0; if_req = 1'b0; bus_ack_i = 1'b1; bus_dat_i = 32'h0000_0099;
    step();
    checks++; if ({bus_cyc_o, if_ack} !== 2'b00 || if_rdata !== 32'h5555_6666) begin
      errors++; $display("FAIL flush_late_ack: got cyc=%0b ack=%0b rdata=%h required 0 0 55556666", bus_cyc_o, if_ack, if_rdata); end
    bus_ack_i = 1'b0;
    $display("txn IF fetch 00000108 flushed");
    // Flush while idle holds off the IF grant for that cycle only.
    if_req = 1'b1; if_addr = 32'h0000_0400; flush = 1'b1;
    step();
    checks++; if (bus_cyc_o !== 1'b0) begin
      errors++; $display("FAIL flush_idle_block: got cyc=%0b required 0", bus_cyc_o); end
    flush = 1'b0;
    step();
    checks++; if (bus_cyc_o !== 1'b1 || bus_adr_o !== 32'h400) begin
      errors++; $display("FAIL flush_idle_grant: got cyc=%0b adr=%h required 1 00000400", bus_cyc_o, bus_adr_o); end
    bus_ack_i = 1'b1; bus_dat_i = 32'h0BAD_F00D;
    step();
    if_req = 1'b0; bus_ack_i = 1'b0;
    step();
    $display("txn IF fetch 00000400 after idle flush rdata=%h", if_rdata);
    // Flush must not disturb a data access.
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_020C;
    step();
    flush = 1'b1;
    step();
    checks++; if (bus_cyc_o !== 1'b1) begin
      errors++; $display("FAIL flush_mem_hold: got cyc=%0b required 1", bus_cyc_o); end
    bus_ack_i = 1'b1; bus_dat_i = 32'h7777_8888;
    step();
    checks++; if (mem_ack !== 1'b1 || mem_rdata !== 32'h7777_8888) begin
      errors++; $display("FAIL flush_mem_ack: got ack=%0b rdata=%h required 1 77778888", mem_ack, mem_rdata); end
    mem_req = 1'b0; bus_ack_i = 1'b0; flush = 1'b0;
    step();
    $display("txn MEM load 0000020c under flush rdata=%h", mem_rdata);
  endtask

  task automatic test_reset_mid();
    mem_req = 1'b1; mem_we = 1'b1; mem_sel = 4'hC; mem_addr = 32'h0000_0500; mem_wdata = 32'h1234_5678;
    step();
    checks++; if (bus_cyc_o !== 1'b1) begin
      errors++; $display("FAIL rstmid_start: got cyc=%0b required 1", bus_cyc_o); end
    rst = 1'b1; bus_ack_i = 1'b1;
    step();
    checks++; if ({bus_cyc_o, bus_stb_o, bus_we_o, bus_sel_o, bus_adr_o, bus_dat_o} !== 71'd0 ||
                  {mem_ack, if_ack, bus_err} !== 3'b000 || {mem_rdata, if_rdata} !== 64'd0) begin
      errors++; $display("FAIL rstmid_clear: got cyc=%0b we=%0b sel=%h adr=%h ack=%0b rdata=%h required all 0", bus_cyc_o, bus_we_o, bus_sel_o, bus_adr_o, mem_ack, mem_rdata); end
    rst = 1'b0; mem_req = 1'b0; bus_ack_i = 1'b0;
    step();
    checks++; if ({bus_cyc_o, mem_ack} !== 2'b00) begin
      errors++; $display("FAIL rstmid_idle: got cyc=%0b ack=%0b required 0 0", bus_cyc_o, mem_ack); end
    $display("txn MEM store 00000500 reset mid-cycle");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_if_only();
    test_simultaneous();
    test_store();
    test_timeout();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
